// File: rtl/fsm_ctrl_pkg.sv
// Shared types and constants for the second-generation accumulator CPU controller.
package fsm_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT           = 4'd0,
    ST_FETCH_INS      = 4'd1,
    ST_FETCH_INS_WAIT = 4'd2,
    ST_DECODE         = 4'd3,
    ST_FETCH_OP       = 4'd4,
    ST_FETCH_OP_WAIT  = 4'd5,
    ST_EXE_ALU        = 4'd6,
    ST_EXE_JMP        = 4'd7,
    ST_STORE          = 4'd8,
    ST_STORE_WAIT     = 4'd9,
    ST_HALT           = 4'd10,
    ST_TRAP           = 4'd11
  } state_e;

  localparam logic [2:0] OP_NOR  = 3'b000;
  localparam logic [2:0] OP_LDA  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ADDC = 3'b011;
  localparam logic [2:0] OP_STA  = 3'b100;
  localparam logic [2:0] OP_JZ   = 3'b101;
  localparam logic [2:0] OP_JCC  = 3'b110;
  localparam logic [2:0] OP_HLT  = 3'b111;

  localparam logic [2:0] UAL_NOP  = 3'b111;
  localparam logic [2:0] UAL_PASS = 3'b001;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_BUS     = 2'b10
  } trap_cause_e;

  localparam int unsigned WAIT_CNT_W = 16;

  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH_INS_WAIT) || (s == ST_FETCH_OP_WAIT) || (s == ST_STORE_WAIT);
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory wait counter: counts cycles spent in a wait state and reports
// access completion (fixed latency or mem_ready) and the mem_ready watchdog.
module mem_wait_ctr
  import fsm_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned USE_READY = 0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic in_wait_i,
  input  logic mem_ready_i,
  output logic done_o,
  output logic timeout_o
);

  localparam logic [WAIT_CNT_W-1:0] LAT_LAST = WAIT_CNT_W'(MEM_LAT - 32'd1);
  localparam logic [WAIT_CNT_W-1:0] TMO_LAST = WAIT_CNT_W'(TIMEOUT - 32'd1);
  localparam logic [WAIT_CNT_W-1:0] CNT_MAX  = {WAIT_CNT_W{1'b1}};

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Completion and watchdog decode; both are meaningful only inside a wait state.
  always_comb begin
    done_o    = 1'b0;
    timeout_o = 1'b0;
    if (in_wait_i) begin
      if (USE_READY != 32'd0) begin
        done_o    = mem_ready_i;
        timeout_o = !mem_ready_i && (cnt_q == TMO_LAST);
      end else begin
        done_o    = (cnt_q == LAT_LAST);
        timeout_o = 1'b0;
      end
    end else begin
      done_o    = 1'b0;
      timeout_o = 1'b0;
    end
  end

  // Counter restarts outside wait states so every wait begins at zero; saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (!in_wait_i || done_o) begin
      cnt_d = {WAIT_CNT_W{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, frozen while ce is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {WAIT_CNT_W{1'b0}};
    end else if (ce) begin
      cnt_q <= cnt_d;
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/fsm_ctrl_v2.sv
// Control FSM for the accumulator CPU: fetch/decode/operand/execute/store
// sequencing with configurable memory latency, watchdog and trap handling.
module fsm_ctrl_v2
  import fsm_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned USE_READY = 0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       boot,
  input  logic [2:0] code_op,
  input  logic       carry,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       clear_PC,
  output logic       enable_PC,
  output logic       load_PC,
  output logic       load_RI,
  output logic       sel_ADR,
  output logic       load_R1,
  output logic       load_ACCU,
  output logic [2:0] sel_UAL,
  output logic       clear_carry,
  output logic       load_carry,
  output logic       enable_mem,
  output logic       W_mem,
  output logic       halted,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       instr_done
);

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;

  logic in_wait_s, done_s, timeout_s;
  logic abort_s, done_ok_s, tmo_ok_s, jmp_taken_s;

  assign in_wait_s   = is_wait_state(state_q);
  // boot wins over completion and watchdog so an abandoned access never retires.
  assign abort_s     = boot & ce;
  assign done_ok_s   = done_s & ~abort_s;
  assign tmo_ok_s    = timeout_s & ~abort_s;
  assign jmp_taken_s = ((code_op == OP_JCC) && !carry) || ((code_op == OP_JZ) && zero);
  assign trap_cause  = cause_q;

  mem_wait_ctr #(
    .MEM_LAT   (MEM_LAT),
    .USE_READY (USE_READY),
    .TIMEOUT   (TIMEOUT)
  ) u_wait (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .in_wait_i   (in_wait_s),
    .mem_ready_i (mem_ready),
    .done_o      (done_s),
    .timeout_o   (timeout_s)
  );

  // Next-state and control decode.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    clear_PC    = 1'b0;
    enable_PC   = 1'b0;
    load_PC     = 1'b0;
    load_RI     = 1'b0;
    sel_ADR     = 1'b0;
    load_R1     = 1'b0;
    load_ACCU   = 1'b0;
    sel_UAL     = UAL_NOP;
    clear_carry = 1'b0;
    load_carry  = 1'b0;
    enable_mem  = 1'b0;
    W_mem       = 1'b0;
    halted      = 1'b0;
    trap        = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      ST_INIT: begin
        clear_PC    = 1'b1;
        clear_carry = 1'b1;
        state_d     = ST_FETCH_INS;
      end
      ST_FETCH_INS: begin
        enable_mem = 1'b1;
        state_d    = ST_FETCH_INS_WAIT;
      end
      ST_FETCH_INS_WAIT: begin
        if (tmo_ok_s) begin
          state_d = ST_TRAP;
          cause_d = TC_BUS;
        end else begin
          enable_mem = 1'b1;
          load_RI    = done_ok_s;
          state_d    = done_ok_s ? ST_DECODE : ST_FETCH_INS_WAIT;
        end
      end
      ST_DECODE: begin
        sel_ADR = 1'b1;
        case (code_op)
          OP_STA:                           state_d = ST_STORE;
          OP_JCC, OP_JZ:                    state_d = ST_EXE_JMP;
          OP_HLT:                           state_d = ST_HALT;
          OP_NOR, OP_LDA, OP_ADD, OP_ADDC:  state_d = ST_FETCH_OP;
          default: begin
            state_d = ST_TRAP;
            cause_d = TC_ILLEGAL;
          end
        endcase
      end
      ST_FETCH_OP: begin
        sel_ADR    = 1'b1;
        enable_mem = 1'b1;
        state_d    = ST_FETCH_OP_WAIT;
      end
      ST_FETCH_OP_WAIT: begin
        if (tmo_ok_s) begin
          state_d = ST_TRAP;
          cause_d = TC_BUS;
        end else begin
          sel_ADR    = 1'b1;
          enable_mem = 1'b1;
          load_R1    = done_ok_s;
          state_d    = done_ok_s ? ST_EXE_ALU : ST_FETCH_OP_WAIT;
        end
      end
      ST_EXE_ALU: begin
        sel_ADR    = 1'b1;
        load_ACCU  = 1'b1;
        enable_PC  = 1'b1;
        instr_done = 1'b1;
        sel_UAL    = (code_op == OP_LDA) ? UAL_PASS : code_op;
        load_carry = code_op[1];
        state_d    = ST_FETCH_INS;
      end
      ST_EXE_JMP: begin
        sel_ADR     = 1'b1;
        instr_done  = 1'b1;
        load_PC     = jmp_taken_s;
        enable_PC   = ~jmp_taken_s;
        clear_carry = ~jmp_taken_s && (code_op == OP_JCC);
        state_d     = ST_FETCH_INS;
      end
      ST_STORE: begin
        sel_ADR    = 1'b1;
        enable_mem = 1'b1;
        W_mem      = 1'b1;
        state_d    = ST_STORE_WAIT;
      end
      ST_STORE_WAIT: begin
        if (tmo_ok_s) begin
          state_d = ST_TRAP;
          cause_d = TC_BUS;
        end else begin
          sel_ADR    = 1'b1;
          enable_mem = 1'b1;
          enable_PC  = done_ok_s;
          instr_done = done_ok_s;
          state_d    = done_ok_s ? ST_FETCH_INS : ST_STORE_WAIT;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (abort_s) begin
      state_d = ST_INIT;
      cause_d = TC_NONE;
    end else begin
      cause_d = cause_d;
    end
  end

  // State and trap-cause registers, frozen while ce is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cause_q <= TC_NONE;
    end else if (ce) begin
      state_q <= state_d;
      cause_q <= cause_d;
    end else begin
      state_q <= state_q;
      cause_q <= cause_q;
    end
  end

endmodule
